gcd_dispatch: RTL and testbench
===============================

# gcd_dispatch

Operand-queue and result-capture front end for the `gcd` subtractive GCD core. Accepts 8-bit operand pairs on a valid/ready stream, buffers them in a small FIFO, issues each pair to the core with a one-cycle `ld` pulse, captures the one-cycle `rdy`/`q` result, and holds it on a valid/ready output stream together with the core's cycle count. Zero operands, which never terminate in the core, are resolved locally.

## Interface
- `DEPTH`, 4: input FIFO entries; power of two, minimum 2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; clears all state. The top level drives the core's active-high `reset` from `~reset`.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: FIFO not full.
- `in_a`, `in_b` input 8 each: operands.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer accepts the result.
- `out_q` output 8: GCD result.
- `out_cycles` output 9: core cycles, saturating at 511.
- `core_ld` output 1: load pulse to the core.
- `core_a`, `core_b` output 8 each: operands to the core.
- `core_q` input 8: core result.
- `core_rdy` input 1: core result strobe, one cycle.

## Operation
- Push when `in_valid && in_ready`. `in_ready = (count != DEPTH)`. There is no pass-through; a push into an empty FIFO is visible at the head on the next cycle.
- Circular FIFO with wrapping read and write pointers plus a count. A simultaneous push and pop leaves the count unchanged. A pop never happens when the FIFO is empty.
- States: S_IDLE, S_ISSUE, S_WAIT, S_HOLD.
- **S_IDLE**, FIFO non-empty:
  - Pop the head into the operand registers `opa`/`opb`.
  - If `opa == 0` or `opb == 0`: load the result register with `a | b` and set cycles to 0, then go to S_HOLD. This gives gcd(0,x)=x and gcd(0,0)=0.
  - Otherwise go to S_ISSUE.
- **S_ISSUE**: `core_ld = 1` for exactly one cycle. Clear the cycle counter. Go to S_WAIT.
- **S_WAIT**:
  - The counter increments by 1 each cycle, including the `core_rdy` cycle, and saturates at 511.
  - On `core_rdy`, capture `core_q` into `out_q` and the counter value plus this cycle into `out_cycles`, then go to S_HOLD.
- **S_HOLD**: `out_valid = 1` with `out_q`/`out_cycles` stable. On `out_ready`, go to S_IDLE. No new job is popped until the result is accepted.
- `core_a`/`core_b` are driven continuously from `opa`/`opb`, so they are stable from S_ISSUE through S_WAIT.
- `core_rdy` outside S_WAIT is ignored.
- `core_ld` is asserted only in S_ISSUE.
- Reset values:
  - Outputs: `in_ready = 1`; `out_valid`, `out_q`, `out_cycles`, `core_ld`, `core_a`, `core_b` all 0.
  - Internal: FIFO empty, state S_IDLE.
- Reset mid-job: the job is lost, the FIFO is flushed, and the core is reset by the same event. There is no recovery of in-flight data.

## Timing
- Push accepted at the edge ending cycle t, with the FIFO empty and the block in S_IDLE:
  - t+1: pop (S_IDLE).
  - t+2: `core_ld = 1`.
  - t+3: first core-active cycle.
- `core_rdy` arrives in cycle t+2+N, where N is the number of core-active cycles (equality check included). `out_valid` rises in t+3+N and `out_cycles = N`.
- Zero bypass: `out_valid` in t+2.
- `out_valid` and `out_ready` in the same cycle: transfer completes. S_IDLE in the next cycle may pop the following entry, so back-to-back jobs have a 1-cycle S_IDLE gap.
- `in_ready` falls in the cycle after the DEPTH-th unpopped push. It rises in the cycle after a pop from a full FIFO.
- `out_valid` is held indefinitely while `out_ready = 0`, and `in_ready` stays 0 once the FIFO fills.

## Test plan
- **Reset:** assert `reset = 0` for 3 cycles, then release -> all outputs at their reset values and `in_ready = 1`.
- **Single job:** push (12,18), `out_ready = 1` -> `core_ld` high exactly one cycle with `core_a = 12`, `core_b = 18`; `out_q = 6` and `out_cycles = 3`. Also push (6,6) -> `out_q = 6`, `out_cycles = 1`, `out_valid` 4 cycles after the push edge.
- **Worst case:** push (255,1) -> `out_q = 1`, `out_cycles = 255`.
- **Zero bypass:** push (0,9), (7,0), (0,0) -> results 9, 7, 0, each with `out_cycles = 0`; `core_ld` never asserted.
- **Backpressure and full:** hold `out_ready = 0` and push DEPTH+2 pairs -> `in_ready` drops after the FIFO fills and the result is held stable. Then release `out_ready` -> all results emerge in push order with nothing lost or duplicated.
- **Reset mid-job:** push (200,3), pulse `reset` low during S_WAIT -> no `out_valid`, FIFO empty. A subsequent push of (8,12) -> `out_q = 4`.

Source files
------------

// File: rtl/gcd_dispatch.sv
// gcd_dispatch: operand FIFO plus issue/capture FSM in front of the subtractive gcd core.
// Zero operands are answered locally because the core never terminates on them.
module gcd_dispatch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_q,
  output logic [8:0] out_cycles,
  output logic       core_ld,
  output logic [7:0] core_a,
  output logic [7:0] core_b,
  input  logic [7:0] core_q,
  input  logic       core_rdy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e state_q, state_d;

  logic [7:0]      mem_a [DEPTH];
  logic [7:0]      mem_b [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;

  logic       push, pop, fifo_empty, head_zero;
  logic [7:0] head_a, head_b;
  logic [7:0] opa_q, opb_q, res_q;
  logic [8:0] cnt_q, cyc_q, cnt_inc;

  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != CntW'(DEPTH));
  assign push       = in_valid && in_ready;
  // Only the idle FSM drains the FIFO, and never from an empty one.
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign head_a     = mem_a[rptr_q];
  assign head_b     = mem_b[rptr_q];
  assign head_zero  = (head_a == 8'd0) || (head_b == 8'd0);
  assign cnt_inc    = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;

  assign core_a     = opa_q;
  assign core_b     = opb_q;
  assign out_q      = res_q;
  assign out_cycles = cyc_q;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wptr_q] <= in_a;
      mem_b[wptr_q] <= in_b;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = head_zero ? StHold : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (core_rdy) state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    core_ld   = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIssue: core_ld   = 1'b1;
      StHold:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand, cycle counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      cyc_q <= '0;
      cnt_q <= '0;
    end else begin
      if (pop) begin
        opa_q <= head_a;
        opb_q <= head_b;
        // gcd(0,x) = x and gcd(0,0) = 0 both reduce to a bitwise OR.
        if (head_zero) begin
          res_q <= head_a | head_b;
          cyc_q <= '0;
        end
      end
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_inc;
        // The strobe cycle itself counts as a core cycle.
        if (core_rdy) begin
          res_q <= core_q;
          cyc_q <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch: table vectors, randomized jobs against a Euclid reference, plus
// backpressure and mid-job reset sequences. A behavioural subtractive core is modelled here.
module tb_gcd_dispatch;

  localparam int DEPTH = 4;
  localparam int NBP   = DEPTH + 2;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_q;
  logic [8:0] out_cycles;
  logic       core_ld;
  logic [7:0] core_a, core_b;
  logic [7:0] core_q;
  logic       core_rdy;

  int n_checks = 0;
  int n_errors = 0;

  gcd_dispatch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_q      (out_q),
    .out_cycles (out_cycles),
    .core_ld    (core_ld),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_q     (core_q),
    .core_rdy   (core_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subtractive core: one compare-or-subtract per cycle, strobes rdy when operands match.
  logic [7:0] ca, cb;
  logic       busy;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      ca   <= '0;
      cb   <= '0;
    end else if (core_ld) begin
      busy <= 1'b1;
      ca   <= core_a;
      cb   <= core_b;
    end else if (busy) begin
      if (ca == cb)     busy <= 1'b0;
      else if (ca > cb) ca <= ca - cb;
      else              cb <= cb - ca;
    end
  end
  assign core_rdy = busy && (ca == cb);
  assign core_q   = busy ? ca : 8'h00;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [8:0] cyc;
  } vec_t;

  typedef struct packed {
    logic [7:0] q;
    logic [8:0] cyc;
  } res_t;

  function automatic logic [7:0] ref_gcd(input int a_in, input int b_in);
    int a = a_in, b = b_in, t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return 8'(a);
  endfunction

  // Core cycles equal the sum of Euclid quotients (subtractions plus the final equal compare).
  function automatic logic [8:0] ref_cycles(input int a_in, input int b_in);
    int a = a_in, b = b_in, t, sum = 0;
    if (a == 0 || b == 0) return 9'd0;
    while (b != 0) begin
      sum += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    if (sum > 511) sum = 511;
    return 9'(sum);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a pair until accepted; returns just after the accepting edge.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Push one job into an idle, empty block with out_ready high and check result and timing.
  task automatic do_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [8:0] ec, input string name);
    int lat, ld_n, ld_lat;
    bit ok, seen, zero;
    zero = (a == 8'd0) || (b == 8'd0);
    push_pair(a, b, ok);
    check({name, " accepted"}, 32'(ok), 32'd1);
    lat = 0; ld_n = 0; ld_lat = 0; seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      lat++;
      if (core_ld) begin
        ld_n++;
        ld_lat = lat;
        check({name, " core_a"}, 32'(core_a), 32'(a));
        check({name, " core_b"}, 32'(core_b), 32'(b));
      end
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " out_valid seen"}, 32'(seen), 32'd1);
    check({name, " out_q"}, 32'(out_q), 32'(eq));
    check({name, " out_cycles"}, 32'(out_cycles), 32'(ec));
    check({name, " latency"}, 32'(lat), zero ? 32'd2 : 32'(ec) + 32'd3);
    check({name, " core_ld pulses"}, 32'(ld_n), zero ? 32'd0 : 32'd1);
    if (!zero) check({name, " core_ld cycle"}, 32'(ld_lat), 32'd2);
    @(posedge clk);
    #1;
  endtask

  vec_t       vecs[9];
  res_t       expq[$];
  res_t       r;
  logic [7:0] bpa[NBP], bpb[NBP];
  logic [7:0] ra, rb;
  int         idx, n_res, n_extra, n_ld;
  bit         ok, push_now;

  initial begin
    vecs[0] = '{8'd12,  8'd18, 8'd6, 9'd3};
    vecs[1] = '{8'd6,   8'd6,  8'd6, 9'd1};
    vecs[2] = '{8'd255, 8'd1,  8'd1, 9'd255};
    vecs[3] = '{8'd0,   8'd9,  8'd9, 9'd0};
    vecs[4] = '{8'd7,   8'd0,  8'd7, 9'd0};
    vecs[5] = '{8'd0,   8'd0,  8'd0, 9'd0};
    vecs[6] = '{8'd21,  8'd14, 8'd7, 9'd3};
    vecs[7] = '{8'd1,   8'd1,  8'd1, 9'd1};
    vecs[8] = '{8'd9,   8'd12, 8'd3, 9'd4};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_q", 32'(out_q), 32'd0);
    check("reset out_cycles", 32'(out_cycles), 32'd0);
    check("reset core_ld", 32'(core_ld), 32'd0);
    check("reset core_a", 32'(core_a), 32'd0);
    check("reset core_b", 32'(core_b), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++)
      do_job(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].cyc, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_job(ra, rb, ref_gcd(ra, rb), ref_cycles(ra, rb), $sformatf("rand%0d", i));
    end

    // Backpressure: hold the consumer off, overfill, then drain in order.
    for (int i = 0; i < NBP; i++) begin
      bpa[i] = 8'($urandom_range(1, 30));
      bpb[i] = 8'($urandom_range(1, 30));
    end
    out_ready = 1'b0;
    idx = 0;
    n_res = 0;
    in_valid = 1'b1;
    in_a = bpa[0];
    in_b = bpb[0];
    for (int cyc = 0; cyc < 4000 && n_res < NBP; cyc++) begin
      @(negedge clk);
      push_now = in_valid && in_ready;
      if ((cyc == 40 || cyc == 60) && expq.size() > 0) begin
        check("bp held out_valid", 32'(out_valid), 32'd1);
        check("bp held out_q", 32'(out_q), 32'(expq[0].q));
        check("bp held out_cycles", 32'(out_cycles), 32'(expq[0].cyc));
      end
      if (cyc == 60) begin
        check("bp in_ready full", 32'(in_ready), 32'd0);
        check("bp accepted while full", 32'(idx), 32'(DEPTH + 1));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("bp unexpected result", 32'd1, 32'd0);
        end else begin
          r = expq.pop_front();
          check($sformatf("bp result%0d q", n_res), 32'(out_q), 32'(r.q));
          check($sformatf("bp result%0d cycles", n_res), 32'(out_cycles), 32'(r.cyc));
        end
        n_res++;
      end
      @(posedge clk);
      #1;
      if (push_now) begin
        expq.push_back('{q: ref_gcd(bpa[idx], bpb[idx]), cyc: ref_cycles(bpa[idx], bpb[idx])});
        idx++;
        if (idx < NBP) begin
          in_a = bpa[idx];
          in_b = bpb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (cyc == 60) out_ready = 1'b1;
    end
    check("bp results count", 32'(n_res), 32'(NBP));
    check("bp pushes count", 32'(idx), 32'(NBP));
    check("bp leftover expected", 32'(expq.size()), 32'd0);
    n_extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) n_extra++;
    end
    check("bp duplicate results", 32'(n_extra), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-job with a second entry queued: both must vanish.
    push_pair(8'd200, 8'd3, ok);
    check("mid reset push1", 32'(ok), 32'd1);
    push_pair(8'd5, 8'd10, ok);
    check("mid reset push2", 32'(ok), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    check("mid reset busy no out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("in reset out_valid", 32'(out_valid), 32'd0);
    check("in reset in_ready", 32'(in_ready), 32'd1);
    check("in reset core_a", 32'(core_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    n_extra = 0;
    n_ld = 0;
    repeat (120) begin
      @(negedge clk);
      if (out_valid) n_extra++;
      if (core_ld) n_ld++;
    end
    check("post reset out_valid", 32'(n_extra), 32'd0);
    check("post reset core_ld", 32'(n_ld), 32'd0);
    @(posedge clk);
    #1;
    do_job(8'd8, 8'd12, 8'd4, 9'd3, "post reset job");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
